// File: rtl/aes_pkg.sv
// Shared types and constants for the AES job scheduler: FSM states,
// key-length codes, round counts and the klen -> Nr mapping.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_CLEAR,
    ST_RUN,
    ST_RESP
  } sched_state_e;

  localparam logic [1:0] KLEN_128 = 2'b00;
  localparam logic [1:0] KLEN_192 = 2'b01;
  localparam logic [1:0] KLEN_256 = 2'b10;
  localparam logic [1:0] KLEN_BAD = 2'b11;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Illegal key length maps to 0; such jobs never reach the cores.
  function automatic logic [3:0] klen_to_nr(input logic [1:0] klen);
    case (klen)
      KLEN_128: return NR_128;
      KLEN_192: return NR_192;
      KLEN_256: return NR_256;
      default:  return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin pick. The pointer names the requester that wins a
// tie; after a grant it moves to the other requester.
module aes_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       req_any,
  output logic       sel
);

  logic rr_ptr;

  assign req_any = |req;
  assign sel     = req[rr_ptr] ? rr_ptr : ~rr_ptr;

  // Pointer moves past the requester that was actually granted.
  always_ff @(posedge clk) begin
    if (rst)      rr_ptr <= 1'b0;
    else if (upd) rr_ptr <= ~upd_id;
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES forward/inverse core pair between two requesters.
// One job in flight: IDLE -> GRANT -> CLEAR -> RUN -> RESP.
// Optional watchdog on RUN: define AES_SCHED_TIMEOUT_EN.
module aes_job_scheduler
  import aes_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int GUARD_CYC = 2,
  parameter int MAX_CYC   = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_dir,
  input  logic [NREQ-1:0][1:0]   req_klen,
  input  logic [NREQ-1:0][127:0] req_data,
  output logic                   core_cs_enc,
  output logic                   core_cs_dec,
  output logic [3:0]             core_nr,
  output logic [127:0]           core_init,
  input  logic                   core_flag_enc,
  input  logic                   core_flag_dec,
  input  logic [127:0]           core_out_enc,
  input  logic [127:0]           core_out_dec,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_id,
  output logic [127:0]           resp_data,
  output logic                   resp_err
);

  localparam int CNT_W = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD_CYC);
`ifdef AES_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(MAX_CYC - 1);
`endif

  sched_state_e     state, state_nx;
  logic             sel_q;
  logic             job_dir;
  logic [CNT_W-1:0] cnt;
  logic             arb_any, arb_sel;
  logic             take, flag_ok, timeout;

  aes_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .upd     (take),
    .upd_id  (sel_q),
    .req_any (arb_any),
    .sel     (arb_sel)
  );

  // Requester still presenting its job when the grant pulse is up.
  assign take = (state == ST_GRANT) && req_valid[sel_q];

  // Core flag stays high from the previous job for a few cycles after cs
  // rises, so it only counts once the guard window has passed.
  assign flag_ok = (job_dir ? core_flag_dec : core_flag_enc) && (cnt >= GUARD_C);

`ifdef AES_SCHED_TIMEOUT_EN
  assign timeout = !flag_ok && (cnt == LAST_C);
`else
  assign timeout = 1'b0;
`endif

  // State register plus job/response latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= 1'b0;
      job_dir   <= 1'b0;
      cnt       <= '0;
      core_nr   <= '0;
      core_init <= '0;
      resp_id   <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (arb_any) sel_q <= arb_sel;
        ST_GRANT: if (take) begin
          job_dir   <= req_dir[sel_q];
          core_nr   <= klen_to_nr(req_klen[sel_q]);
          core_init <= req_data[sel_q];
          resp_id   <= sel_q;
          resp_err  <= (req_klen[sel_q] == KLEN_BAD);
          resp_data <= '0;
        end
        ST_CLEAR: cnt <= '0;
        ST_RUN: begin
          if (cnt != '1) cnt <= cnt + 1'b1;
          if (flag_ok)      resp_data <= job_dir ? core_out_dec : core_out_enc;
          else if (timeout) resp_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_nx    = state;
    req_ready   = '0;
    core_cs_enc = 1'b0;
    core_cs_dec = 1'b0;
    resp_valid  = 1'b0;
    case (state)
      ST_IDLE: if (arb_any) state_nx = ST_GRANT;
      ST_GRANT: begin
        req_ready[sel_q] = 1'b1;
        if (!take)                              state_nx = ST_IDLE;
        else if (req_klen[sel_q] == KLEN_BAD)   state_nx = ST_RESP;
        else                                    state_nx = ST_CLEAR;
      end
      ST_CLEAR: state_nx = ST_RUN;
      ST_RUN: begin
        core_cs_enc = !job_dir;
        core_cs_dec = job_dir;
        if (flag_ok || timeout) state_nx = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
